// File: rtl/tbu_block.sv
// Block-mode Viterbi traceback: circular survivor buffer, periodic traceback, serial bit output.
// Optional macro TBU_OVERRUN_EN adds a sticky overrun flag for column-rate violations.
module tbu_block #(
  parameter int NUM_STATES = 64,
  parameter int TB_DEPTH   = 32,
  parameter int DEC_LEN    = 40,
  localparam int SW        = $clog2(NUM_STATES)
) (
  input  logic                           clk,
  input  logic                           sys_rst_n,
  input  logic [NUM_STATES-1:0][SW-1:0]  prev_state,
  input  logic [NUM_STATES-1:0]          desc,
  input  logic [SW-1:0]                  best_state,
  input  logic                           valid_in,
  output logic                           vit_desc,
  output logic                           valid_out,
  output logic                           busy
`ifdef TBU_OVERRUN_EN
  ,
  output logic                           overrun
`endif
);

  localparam int TOTAL     = TB_DEPTH + DEC_LEN;
  localparam int MEM_DEPTH = TB_DEPTH + 2 * DEC_LEN;
  localparam int PW        = $clog2(MEM_DEPTH);
  localparam int CW        = $clog2(TOTAL + 1);
  localparam int BW        = $clog2(DEC_LEN);
  localparam logic [PW-1:0] LAST_COL = PW'(MEM_DEPTH - 1);

  typedef enum logic {IDLE, TRACE} state_t;
  state_t state, state_nxt;

  logic [NUM_STATES-1:0]         mem_desc [MEM_DEPTH];
  logic [NUM_STATES-1:0][SW-1:0] mem_prev [MEM_DEPTH];
  logic [NUM_STATES-1:0]         rd_desc;
  logic [NUM_STATES-1:0][SW-1:0] rd_prev;

  logic [PW-1:0]      wptr, rd_ptr;
  logic [CW-1:0]      col_cnt, tr_cnt;
  logic [BW-1:0]      blk_cnt, out_left;
  logic [SW-1:0]      cur_state;
  logic [DEC_LEN-1:0] result, result_nxt, out_sh;
  logic               col_full, trigger, start, trace_done;

  assign col_full   = (col_cnt == CW'(TOTAL));
  assign trigger    = valid_in && ((col_cnt == CW'(TOTAL - 1)) ||
                                   (col_full && (blk_cnt == BW'(DEC_LEN - 1))));
  // A trigger arriving mid-traceback is dropped; the running trace is left untouched.
  assign start      = trigger && (state == IDLE);
  assign trace_done = (state == TRACE) && (tr_cnt == CW'(TOTAL));
  assign result_nxt = {result[DEC_LEN-2:0], rd_desc[cur_state]};

  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem_desc[wptr] <= desc;
      mem_prev[wptr] <= prev_state;
    end
  end

  always_ff @(posedge clk) begin
    rd_desc <= mem_desc[rd_ptr];
    rd_prev <= mem_prev[rd_ptr];
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr    <= '0;
      col_cnt <= '0;
      blk_cnt <= '0;
    end else if (valid_in) begin
      wptr <= (wptr == LAST_COL) ? '0 : wptr + 1'b1;
      if (!col_full) col_cnt <= col_cnt + 1'b1;
      if (trigger)       blk_cnt <= '0;
      else if (col_full) blk_cnt <= blk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = TRACE;
      TRACE:   if (tr_cnt == CW'(TOTAL)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == TRACE);
  end

  // Read data lags the address by one cycle, so step k is processed when tr_cnt == k+1.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tr_cnt    <= '0;
      rd_ptr    <= '0;
      cur_state <= '0;
      result    <= '0;
    end else if (start) begin
      tr_cnt    <= '0;
      rd_ptr    <= wptr;
      cur_state <= best_state;
    end else if (state == TRACE) begin
      tr_cnt <= tr_cnt + 1'b1;
      rd_ptr <= (rd_ptr == '0) ? LAST_COL : rd_ptr - 1'b1;
      if (tr_cnt != '0) begin
        cur_state <= rd_prev[cur_state];
        if (tr_cnt > CW'(TB_DEPTH)) result <= result_nxt;
      end
    end
  end

  // The oldest column ends up in bit 0, so the shifter emits LSB first.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vit_desc  <= 1'b0;
      valid_out <= 1'b0;
      out_sh    <= '0;
      out_left  <= '0;
    end else if (trace_done) begin
      vit_desc  <= result_nxt[0];
      valid_out <= 1'b1;
      out_sh    <= {1'b0, result_nxt[DEC_LEN-1:1]};
      out_left  <= BW'(DEC_LEN - 1);
    end else if (out_left != '0) begin
      vit_desc  <= out_sh[0];
      valid_out <= 1'b1;
      out_sh    <= {1'b0, out_sh[DEC_LEN-1:1]};
      out_left  <= out_left - 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

`ifdef TBU_OVERRUN_EN
  logic valid_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if ((valid_in && valid_q) || (trigger && (state == TRACE))) overrun <= 1'b1;
    end
  end
`endif

endmodule
